// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Stalls the upstream pipeline while computing and presents the result
// with a one-cycle done pulse toward the EX/MEM register.
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [2:0]       func3_i,
  input  logic [WIDTH-1:0] rs1_data_i,
  input  logic [WIDTH-1:0] rs2_data_i,
  input  logic [4:0]       rd_addr_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [4:0]       rd_addr_o
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         func3_q, func3_d;
  logic [4:0]         rd_q, rd_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   result_q, result_d;

  // Operand magnitudes and signs for the E0 capture
  logic             s1, s2;
  logic [WIDTH-1:0] abs1, abs2;

  // Single-iteration datapath results
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     dshift;
  logic [WIDTH+1:0]   dsub;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] step_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, final_res;

  // Upstream hold: only while the op is being accepted or iterated
  assign stall_o   = start_i & ~flush_i & (state_q != S_DONE);
  assign done_o    = (state_q == S_DONE);
  assign result_o  = result_q;
  assign rd_addr_o = rd_q;

  // Iteration datapath and result formatting
  always_comb begin
    s1   = rs1_data_i[WIDTH-1];
    s2   = rs2_data_i[WIDTH-1];
    abs1 = s1 ? (~rs1_data_i + 1'b1) : rs1_data_i;
    abs2 = s2 ? (~rs2_data_i + 1'b1) : rs2_data_i;

    // Shift-add: multiplier sits in the low half and is shifted out LSB first
    msum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {msum, prod_q[WIDTH-1:1]};

    // Restoring divide: {remainder, dividend/quotient} shifts left each step
    dshift   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    dsub     = {1'b0, dshift} - {2'b00, opnd_q};
    div_next = {(dsub[WIDTH+1] ? dshift[WIDTH-1:0] : dsub[WIDTH-1:0]),
                prod_q[WIDTH-2:0], ~dsub[WIDTH+1]};

    step_next = func3_q[2] ? div_next : mul_next;

    prod_fix = neg_q ? (~step_next + 1'b1) : step_next;
    quo_fix  = neg_q ? (~step_next[WIDTH-1:0] + 1'b1) : step_next[WIDTH-1:0];
    rem_fix  = neg_q ? (~step_next[2*WIDTH-1:WIDTH] + 1'b1) : step_next[2*WIDTH-1:WIDTH];

    // MUL never sets the sign flag, so its low word comes through unchanged
    if (!func3_q[2]) begin
      final_res = (func3_q == F_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    end else begin
      final_res = func3_q[1] ? rem_fix : quo_fix;
    end
  end

  // Next-state, operand capture and iteration control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    func3_d  = func3_q;
    rd_d     = rd_q;
    opnd_d   = opnd_q;
    prod_d   = prod_q;
    neg_d    = neg_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          func3_d = func3_i;
          rd_d    = rd_addr_i;
          cnt_d   = '0;
          // opnd holds the multiplicand or divisor; prod low half holds
          // the multiplier or dividend
          unique case (func3_i)
            F_MUL:    begin opnd_d = rs1_data_i; prod_d = {{WIDTH{1'b0}}, rs2_data_i}; neg_d = 1'b0;    end
            F_MULH:   begin opnd_d = abs1;       prod_d = {{WIDTH{1'b0}}, abs2};       neg_d = s1 ^ s2; end
            F_MULHSU: begin opnd_d = abs1;       prod_d = {{WIDTH{1'b0}}, rs2_data_i}; neg_d = s1;      end
            F_MULHU:  begin opnd_d = rs1_data_i; prod_d = {{WIDTH{1'b0}}, rs2_data_i}; neg_d = 1'b0;    end
            F_DIV:    begin opnd_d = abs2;       prod_d = {{WIDTH{1'b0}}, abs1};       neg_d = s1 ^ s2; end
            F_DIVU:   begin opnd_d = rs2_data_i; prod_d = {{WIDTH{1'b0}}, rs1_data_i}; neg_d = 1'b0;    end
            F_REM:    begin opnd_d = abs2;       prod_d = {{WIDTH{1'b0}}, abs1};       neg_d = s1;      end
            F_REMU:   begin opnd_d = rs2_data_i; prod_d = {{WIDTH{1'b0}}, rs1_data_i}; neg_d = 1'b0;    end
            default:  ;
          endcase
          if (func3_i[2] && (rs2_data_i == '0)) begin
            result_d = func3_i[1] ? rs1_data_i : '1;
            state_d  = S_DONE;
          end else if (func3_i[2] && !func3_i[0] &&
                       (rs1_data_i == MIN_NEG) && (rs2_data_i == '1)) begin
            result_d = func3_i[1] ? '0 : MIN_NEG;
            state_d  = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        prod_d = step_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          result_d = final_res;
          cnt_d    = '0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush_i) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      func3_q  <= '0;
      rd_q     <= '0;
      opnd_q   <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      func3_q  <= func3_d;
      rd_q     <= rd_d;
      opnd_q   <= opnd_d;
      prod_q   <= prod_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed RV32M cases, flush and
// reset aborts, then randomized ops against an arithmetic reference model.
module tb_ex_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        flush_i;
  logic [2:0]  func3_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [4:0]  rd_addr_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  int total = 0;
  int bad   = 0;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .flush_i    (flush_i),
    .func3_i    (func3_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .rd_addr_i  (rd_addr_i),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .rd_addr_o  (rd_addr_o)
  );

  always #5 clk_i = ~clk_i;

  // RV32M semantics with plain 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x,
                                            input logic [31:0] y);
    longint          sp;
    longint unsigned up;
    int              sx, sy;
    sx = signed'(x);
    sy = signed'(y);
    case (f)
      3'd0: begin up = {32'b0, x} * {32'b0, y}; return up[31:0]; end
      3'd1: begin sp = longint'(sx) * longint'(sy); return sp[63:32]; end
      3'd2: begin sp = longint'(sx) * longint'({32'b0, y}); return sp[63:32]; end
      3'd3: begin up = {32'b0, x} * {32'b0, y}; return up[63:32]; end
      3'd4: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sx / sy);
      end
      3'd5: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        return x / y;
      end
      3'd6: begin
        if (y == 32'd0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sx % sy);
      end
      default: begin
        if (y == 32'd0) return x;
        return x % y;
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op; leaves start_i high in the done cycle (sampled at negedge+1)
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] x,
                       input logic [31:0] y, input logic [4:0] rd);
    logic [31:0] exp;
    int          exp_stall, nst, waited;
    bit          special;
    exp       = ref_model(f, x, y);
    special   = f[2] && ((y == 32'd0) ||
                (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    exp_stall = special ? 1 : 33;
    @(negedge clk_i);
    start_i    = 1'b1;
    func3_i    = f;
    rs1_data_i = x;
    rs2_data_i = y;
    rd_addr_i  = rd;
    nst        = 0;
    waited     = 0;
    #1;
    while (!done_o && waited < 60) begin
      if (stall_o) nst++;
      waited++;
      @(negedge clk_i);
      // operands after capture must not matter
      rs1_data_i = $urandom;
      rs2_data_i = $urandom;
      #1;
    end
    chk({tag, "_done"}, 32'(done_o), 32'd1);
    chk({tag, "_result"}, result_o, exp);
    chk({tag, "_rd"}, 32'(rd_addr_o), 32'(rd));
    chk({tag, "_stalls"}, 32'(nst), 32'(exp_stall));
    chk({tag, "_stall_in_done"}, 32'(stall_o), 32'd0);
  endtask

  task automatic quiet_cycles(input string tag, input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      #1;
      if (done_o) seen = 1'b1;
    end
    chk({tag, "_no_done"}, 32'(seen), 32'd0);
  endtask

  initial begin
    rst_i      = 1'b0;
    start_i    = 1'b0;
    flush_i    = 1'b0;
    func3_i    = 3'd0;
    rs1_data_i = '0;
    rs2_data_i = '0;
    rd_addr_i  = '0;
    #12;
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_rd", 32'(rd_addr_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    do_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9);
    chk("mul_value", result_o, 32'hFFFF_FFEB);
    do_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);
    chk("mulh_value", result_o, 32'h4000_0000);
    do_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    chk("mulhu_value", result_o, 32'hFFFF_FFFE);
    do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    chk("mulhsu_value", result_o, 32'hFFFF_FFFF);
    do_op("divu", 3'd5, 32'd100, 32'd7, 5'd4);
    chk("divu_value", result_o, 32'd14);
    do_op("remu", 3'd7, 32'd100, 32'd7, 5'd5);
    chk("remu_value", result_o, 32'd2);
    do_op("div", 3'd4, 32'hFFFF_FF9C, 32'd7, 5'd6);
    chk("div_value", result_o, 32'hFFFF_FFF2);
    do_op("rem", 3'd6, 32'hFFFF_FF9C, 32'd7, 5'd7);
    chk("rem_value", result_o, 32'hFFFF_FFFE);
    do_op("div0", 3'd4, 32'd5, 32'd0, 5'd8);
    do_op("rem0", 3'd6, 32'd5, 32'd0, 5'd10);
    chk("rem0_value", result_o, 32'd5);
    do_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    chk("divovf_value", result_o, 32'h8000_0000);
    do_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    chk("removf_value", result_o, 32'd0);
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    chk("after_done_idle", 32'(done_o), 32'd0);

    // Flush at CALC iteration 10
    @(negedge clk_i);
    start_i    = 1'b1;
    func3_i    = 3'd4;
    rs1_data_i = 32'd1000;
    rs2_data_i = 32'd3;
    rd_addr_i  = 5'd13;
    #1;
    chk("flush_start_stall", 32'(stall_o), 32'd1);
    repeat (10) @(negedge clk_i);
    flush_i = 1'b1;
    #1;
    chk("flush_stall_low", 32'(stall_o), 32'd0);
    @(negedge clk_i);
    flush_i = 1'b0;
    start_i = 1'b0;
    #1;
    chk("flush_after_done", 32'(done_o), 32'd0);
    chk("flush_after_stall", 32'(stall_o), 32'd0);
    quiet_cycles("flush", 40);
    do_op("mul34", 3'd0, 32'd3, 32'd4, 5'd14);
    chk("mul34_value", result_o, 32'd12);

    // Asynchronous reset mid-CALC
    @(negedge clk_i);
    func3_i    = 3'd0;
    rs1_data_i = 32'd5;
    rs2_data_i = 32'd6;
    rd_addr_i  = 5'd15;
    repeat (10) @(negedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    chk("midrst_result", result_o, 32'd0);
    chk("midrst_rd", 32'(rd_addr_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    start_i = 1'b0;
    #1;
    chk("midrst_stall", 32'(stall_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    quiet_cycles("midrst", 40);

    do_op("b2b_mul", 3'd0, 32'd1234, 32'd5678, 5'd16);
    do_op("b2b_remu", 3'd7, 32'd1000, 32'd33, 5'd17);

    // Randomized ops, mixing corner operands in
    for (int i = 0; i < 40; i++) begin
      logic [31:0] x, y;
      logic [2:0]  f;
      f = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'($urandom_range(1, 20));
        3: x = 32'hFFFF_FFFF;
        default: ;
      endcase
      do_op("rand", f, x, y, 5'($urandom_range(0, 31)));
    end
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
